// File: rtl/apb_i2c_regif_pkg.sv
// Shared constants for the APB-to-I2C register interface: register map,
// STATUS/IRQ bit positions and the register decode helper.
package apb_i2c_pkg;

  localparam int unsigned IRQ_W = 4;

  localparam logic [31:0] ADDR_TXDATA   = 32'h00;
  localparam logic [31:0] ADDR_RXDATA   = 32'h04;
  localparam logic [31:0] ADDR_CONFIG   = 32'h08;
  localparam logic [31:0] ADDR_TIMEOUT  = 32'h0C;
  localparam logic [31:0] ADDR_STATUS   = 32'h10;
  localparam logic [31:0] ADDR_IRQ_EN   = 32'h14;
  localparam logic [31:0] ADDR_IRQ_STAT = 32'h18;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_RX_EMPTY  = 2;
  localparam int unsigned ST_RX_FULL   = 3;
  localparam int unsigned ST_CORE_ERR  = 4;
  localparam int unsigned ST_TX_LVL_LO = 8;
  localparam int unsigned ST_RX_LVL_LO = 16;

  localparam int unsigned IRQ_TX_DONE  = 0;
  localparam int unsigned IRQ_RX_AVAIL = 1;
  localparam int unsigned IRQ_CORE_ERR = 2;
  localparam int unsigned IRQ_SLVERR   = 3;

  typedef enum logic [2:0] {
    RegTxData, RegRxData, RegConfig, RegTimeout, RegStatus, RegIrqEn, RegIrqStat, RegNone
  } reg_e;

  function automatic reg_e decode_reg(input logic [31:0] addr);
    reg_e r;
    case (addr)
      ADDR_TXDATA:   r = RegTxData;
      ADDR_RXDATA:   r = RegRxData;
      ADDR_CONFIG:   r = RegConfig;
      ADDR_TIMEOUT:  r = RegTimeout;
      ADDR_STATUS:   r = RegStatus;
      ADDR_IRQ_EN:   r = RegIrqEn;
      ADDR_IRQ_STAT: r = RegIrqStat;
      default:       r = RegNone;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_i2c_regif_if.sv
// APB bus bundle between a bus master and the register interface.
interface apb_i2c_regif_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array, written on accepted push only.
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and level bookkeeping; simultaneous push/pop keeps the level.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_i2c_regif.sv
// APB slave register interface for the I2C core: TX/RX FIFOs, CONFIG/TIMEOUT,
// STATUS and a sticky maskable interrupt. Zero wait states.
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CFG_W    = 14,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_i2c_regif_if.slave    bus,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              core_error,
  output logic [CFG_W-1:0]  cfg,
  output logic [CFG_W-1:0]  timeout,
  output logic              irq
);

  localparam int unsigned TLW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RLW = $clog2(RX_DEPTH) + 1;

  logic [31:0]       prdata_q, rdata_d, status;
  logic              pslverr_q, err_d;
  logic [CFG_W-1:0]  cfg_q, timeout_q;
  logic [IRQ_W-1:0]  irq_en_q, irq_stat_q, irq_stat_d, irq_set, irq_clr;
  logic              irq_q, core_err_q;
  logic              setup, access, wr, rd;
  reg_e              sel;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [TLW-1:0]    tx_level;
  logic [RLW-1:0]    rx_level;
  logic [DATA_W-1:0] rx_head;

  assign sel         = decode_reg(32'(bus.PADDR[ADDR_W-1:0]));
  assign setup       = bus.PSEL & ~bus.PENABLE;
  assign bus.PREADY  = bus.PSEL & bus.PENABLE & ~PRESET;
  assign access      = bus.PREADY;
  // Side effects are suppressed for any transfer flagged as an error at setup.
  assign wr          = access & ~pslverr_q & bus.PWRITE;
  assign rd          = access & ~pslverr_q & ~bus.PWRITE;
  assign bus.PRDATA  = prdata_q;
  assign bus.PSLVERR = pslverr_q;

  assign tx_push  = wr & (sel == RegTxData);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full & ~PRESET;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd & (sel == RegRxData);

  assign cfg     = cfg_q;
  assign timeout = timeout_q;
  assign irq     = irq_q;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (tx_push),
    .pop    (tx_pop),
    .wdata  (bus.PWDATA[DATA_W-1:0]),
    .rdata  (tx_data),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (rx_push),
    .pop    (rx_pop),
    .wdata  (rx_data),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level)
  );

  // STATUS word assembled from registered FIFO levels and the live core error.
  always_comb begin
    status                                = '0;
    status[ST_TX_EMPTY]                   = tx_empty;
    status[ST_TX_FULL]                    = tx_full;
    status[ST_RX_EMPTY]                   = rx_empty;
    status[ST_RX_FULL]                    = rx_full;
    status[ST_CORE_ERR]                   = core_error;
    status[ST_TX_LVL_LO +: 8]             = 8'(tx_level);
    status[ST_RX_LVL_LO +: 8]             = 8'(rx_level);
  end

  // Setup-phase decode: read data and error flag captured for the access cycle.
  always_comb begin
    err_d   = 1'b0;
    rdata_d = '0;
    case (sel)
      RegTxData:  err_d = ~bus.PWRITE | tx_full;
      RegRxData: begin
        err_d   = bus.PWRITE | rx_empty;
        rdata_d = 32'(rx_head);
      end
      RegConfig:  rdata_d = 32'(cfg_q);
      RegTimeout: rdata_d = 32'(timeout_q);
      RegStatus: begin
        err_d   = bus.PWRITE;
        rdata_d = status;
      end
      RegIrqEn:   rdata_d = 32'(irq_en_q);
      RegIrqStat: rdata_d = 32'(irq_stat_q);
      default:    err_d = 1'b1;
    endcase
    if (bus.PWRITE || err_d) rdata_d = '0;
  end

  // Sticky interrupt sources; a set beats a W1C clear of the same bit.
  always_comb begin
    irq_set               = '0;
    irq_set[IRQ_TX_DONE]  = (tx_level == TLW'(1)) & tx_pop & ~tx_push;
    irq_set[IRQ_RX_AVAIL] = rx_empty & rx_push;
    irq_set[IRQ_CORE_ERR] = core_error & ~core_err_q;
    irq_set[IRQ_SLVERR]   = access & pslverr_q;
    irq_clr               = (wr && sel == RegIrqStat) ? bus.PWDATA[IRQ_W-1:0] : '0;
    irq_stat_d            = (irq_stat_q & ~irq_clr) | irq_set;
  end

  // Edge detector for core_error, sampled every cycle.
  always_ff @(posedge PCLK) begin
    core_err_q <= core_error;
  end

  // Bus response, control registers and interrupt state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      cfg_q      <= '0;
      timeout_q  <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (setup) begin
        prdata_q  <= rdata_d;
        pslverr_q <= err_d;
      end
      if (wr && sel == RegConfig)  cfg_q     <= bus.PWDATA[CFG_W-1:0];
      if (wr && sel == RegTimeout) timeout_q <= bus.PWDATA[CFG_W-1:0];
      if (wr && sel == RegIrqEn)   irq_en_q  <= bus.PWDATA[IRQ_W-1:0];
      irq_stat_q <= irq_stat_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

endmodule
